// File: rtl/npc_cycle_ctrl_pkg.sv
// Shared definitions for the NPC cycle controller: FSM state encoding,
// instruction class codes, stop-cause codes and the IDU instruction numbers.
package npc_cycle_ctrl_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int INST_NUM_WIDTH = 6;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH_REQ  = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_DECODE     = 4'd3,
        ST_EXEC       = 4'd4,
        ST_MEM_REQ    = 4'd5,
        ST_MEM_WAIT   = 4'd6,
        ST_WB         = 4'd7,
        ST_HALT       = 4'd8,
        ST_ERROR      = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_BRANCH = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_EBREAK = 3'd4,
        CLS_INV    = 3'd5
    } inst_cls_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_INV    = 2'b01;
    localparam logic [1:0] ERR_IFU_TO = 2'b10;
    localparam logic [1:0] ERR_LSU_TO = 2'b11;

    // Instruction numbers produced by the IDU
    localparam logic [INST_NUM_WIDTH-1:0] INST_INV    = 6'd0;
    localparam logic [INST_NUM_WIDTH-1:0] INST_ADDI   = 6'd1;
    localparam logic [INST_NUM_WIDTH-1:0] INST_ADD    = 6'd2;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LUI    = 6'd3;
    localparam logic [INST_NUM_WIDTH-1:0] INST_JAL    = 6'd4;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BEQ    = 6'd5;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BNE    = 6'd6;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BLT    = 6'd7;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BGE    = 6'd8;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BLTU   = 6'd9;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BGEU   = 6'd10;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LB     = 6'd11;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LH     = 6'd12;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LW     = 6'd13;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LBU    = 6'd14;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LHU    = 6'd15;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SB     = 6'd16;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SH     = 6'd17;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SW     = 6'd18;
    localparam logic [INST_NUM_WIDTH-1:0] INST_EBREAK = 6'd19;

endpackage

// File: rtl/npc_cycle_ctrl_inst_class.sv
// npc_inst_class: combinational map from IDU instruction number to the
// class the sequencer branches on in EXEC.
//   i_inst_num : decoded instruction number
//   o_cls      : class code (inst_cls_t encoding)
module npc_inst_class
    import npc_cycle_ctrl_pkg::*;
(
    input  logic [INST_NUM_WIDTH-1:0] i_inst_num,
    output logic [2:0]                o_cls
);

    always_comb begin
        o_cls = CLS_ALU;
        case (i_inst_num)
            INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU:             o_cls = CLS_LOAD;
            INST_SB, INST_SH, INST_SW:                                 o_cls = CLS_STORE;
            INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU: o_cls = CLS_BRANCH;
            INST_EBREAK:                                               o_cls = CLS_EBREAK;
            INST_INV:                                                  o_cls = CLS_INV;
            default:                                                   o_cls = CLS_ALU;
        endcase
    end

endmodule

// File: rtl/npc_cycle_ctrl.sv
// npc_cycle_ctrl: multi-cycle sequencer for the NPC core. Owns PC and IR,
// walks each instruction through fetch/decode/exec/mem/wb and drives only
// the datapath enables.
//   clk, rst                    : clock, async active-low reset
//   pc / pc_next                : current PC (fetch address) / next PC from EXU
//   ifu_req_* / ifu_rsp_*       : instruction memory handshake
//   inst / inst_num             : instruction register / IDU decode result
//   lsu_req_* / lsu_rsp_valid   : data memory handshake
//   rf_wen, commit              : single-cycle pulses at retirement
//   halt, err, err_cause        : sticky stop status
//   cycle_cnt, instret          : performance counters
module npc_cycle_ctrl
    import npc_cycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          MEM_TIMEOUT = 255,
    parameter int          CNT_WIDTH   = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [31:0]               pc,
    input  logic [31:0]               pc_next,
    output logic                      ifu_req_valid,
    input  logic                      ifu_req_ready,
    input  logic                      ifu_rsp_valid,
    input  logic [ISA_WIDTH-1:0]      ifu_rsp_inst,
    output logic [ISA_WIDTH-1:0]      inst,
    input  logic [INST_NUM_WIDTH-1:0] inst_num,
    output logic                      lsu_req_valid,
    output logic                      lsu_req_wen,
    input  logic                      lsu_req_ready,
    input  logic                      lsu_rsp_valid,
    output logic                      rf_wen,
    output logic                      commit,
    output logic                      halt,
    output logic                      err,
    output logic [1:0]                err_cause,
    output logic [CNT_WIDTH-1:0]      cycle_cnt,
    output logic [CNT_WIDTH-1:0]      instret
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t                r_state;
    logic [31:0]           r_pc;
    logic [ISA_WIDTH-1:0]  r_inst;
    logic                  r_ifu_req_valid, r_lsu_req_valid, r_lsu_req_wen;
    logic                  r_rf_wen, r_commit, r_halt, r_err;
    logic [1:0]            r_err_cause;
    logic [CNT_WIDTH-1:0]  r_cycle_cnt, r_instret;
    logic [WAIT_W-1:0]     r_wait;

    logic [2:0]            w_cls;
    logic [WAIT_W:0]       w_wait_inc;
    logic                  w_timeout;

    npc_inst_class u_cls (
        .i_inst_num (inst_num),
        .o_cls      (w_cls)
    );

    // Timeout fires on the cycle whose increment would reach the limit;
    // callers test for a completing response first so it wins that cycle.
    assign w_wait_inc = {1'b0, r_wait} + (WAIT_W+1)'(1);
    assign w_timeout  = (MEM_TIMEOUT != 0) && (w_wait_inc == (WAIT_W+1)'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_pc            <= RESET_PC;
            r_inst          <= '0;
            r_ifu_req_valid <= 1'b0;
            r_lsu_req_valid <= 1'b0;
            r_lsu_req_wen   <= 1'b0;
            r_rf_wen        <= 1'b0;
            r_commit        <= 1'b0;
            r_halt          <= 1'b0;
            r_err           <= 1'b0;
            r_err_cause     <= ERR_NONE;
            r_cycle_cnt     <= '0;
            r_instret       <= '0;
            r_wait          <= '0;
        end else begin
            r_rf_wen <= 1'b0;
            r_commit <= 1'b0;
            if (r_state != ST_HALT && r_state != ST_ERROR)
                r_cycle_cnt <= r_cycle_cnt + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    r_state         <= ST_FETCH_REQ;
                    r_ifu_req_valid <= 1'b1;
                    r_wait          <= '0;
                end
                ST_FETCH_REQ, ST_FETCH_WAIT: begin
                    if ((r_state == ST_FETCH_WAIT || ifu_req_ready) && ifu_rsp_valid) begin
                        r_inst          <= ifu_rsp_inst;
                        r_ifu_req_valid <= 1'b0;
                        r_state         <= ST_DECODE;
                    end else if (w_timeout) begin
                        r_ifu_req_valid <= 1'b0;
                        r_state         <= ST_ERROR;
                        r_halt          <= 1'b1;
                        r_err           <= 1'b1;
                        r_err_cause     <= ERR_IFU_TO;
                    end else begin
                        r_wait <= w_wait_inc[WAIT_W-1:0];
                        if (r_state == ST_FETCH_REQ && ifu_req_ready) begin
                            r_ifu_req_valid <= 1'b0;
                            r_state         <= ST_FETCH_WAIT;
                        end
                    end
                end
                ST_DECODE: r_state <= ST_EXEC;
                ST_EXEC: begin
                    case (w_cls)
                        CLS_LOAD, CLS_STORE: begin
                            r_state         <= ST_MEM_REQ;
                            r_lsu_req_valid <= 1'b1;
                            r_lsu_req_wen   <= (w_cls == CLS_STORE);
                            r_wait          <= '0;
                        end
                        CLS_EBREAK: begin
                            // ebreak retires but leaves pc on its own address
                            r_state   <= ST_HALT;
                            r_halt    <= 1'b1;
                            r_commit  <= 1'b1;
                            r_instret <= r_instret + 1'b1;
                        end
                        CLS_INV: begin
                            r_state     <= ST_ERROR;
                            r_halt      <= 1'b1;
                            r_err       <= 1'b1;
                            r_err_cause <= ERR_INV;
                        end
                        CLS_BRANCH: begin
                            r_state  <= ST_WB;
                            r_commit <= 1'b1;
                        end
                        default: begin
                            r_state  <= ST_WB;
                            r_commit <= 1'b1;
                            r_rf_wen <= 1'b1;
                        end
                    endcase
                end
                ST_MEM_REQ, ST_MEM_WAIT: begin
                    // r_lsu_req_wen is kept through MEM_WAIT: it is the only
                    // record of load vs store when deciding rf_wen for WB.
                    if ((r_state == ST_MEM_WAIT || lsu_req_ready) && lsu_rsp_valid) begin
                        r_lsu_req_valid <= 1'b0;
                        r_lsu_req_wen   <= 1'b0;
                        r_state         <= ST_WB;
                        r_commit        <= 1'b1;
                        r_rf_wen        <= ~r_lsu_req_wen;
                    end else if (w_timeout) begin
                        r_lsu_req_valid <= 1'b0;
                        r_lsu_req_wen   <= 1'b0;
                        r_state         <= ST_ERROR;
                        r_halt          <= 1'b1;
                        r_err           <= 1'b1;
                        r_err_cause     <= ERR_LSU_TO;
                    end else begin
                        r_wait <= w_wait_inc[WAIT_W-1:0];
                        if (r_state == ST_MEM_REQ && lsu_req_ready) begin
                            r_lsu_req_valid <= 1'b0;
                            r_state         <= ST_MEM_WAIT;
                        end
                    end
                end
                ST_WB: begin
                    r_pc            <= pc_next;
                    r_instret       <= r_instret + 1'b1;
                    r_state         <= ST_FETCH_REQ;
                    r_ifu_req_valid <= 1'b1;
                    r_wait          <= '0;
                end
                ST_HALT, ST_ERROR: r_state <= r_state;
                default:           r_state <= ST_IDLE;
            endcase
        end
    end

    assign pc            = r_pc;
    assign inst          = r_inst;
    assign ifu_req_valid = r_ifu_req_valid;
    assign lsu_req_valid = r_lsu_req_valid;
    assign lsu_req_wen   = r_lsu_req_wen;
    assign rf_wen        = r_rf_wen;
    assign commit        = r_commit;
    assign halt          = r_halt;
    assign err           = r_err;
    assign err_cause     = r_err_cause;
    assign cycle_cnt     = r_cycle_cnt;
    assign instret       = r_instret;

endmodule
